// File: rtl/wb_write_arbiter.sv
// Write-back arbiter: merges pipeline write-back with queued long-latency results onto one RF write port.
// Optional macro WB_BYPASS_EN enables combinational read bypass from the registered write port.
module wb_write_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clk_enable,
    input  logic        i_pipe_we,
    input  logic [4:0]  i_pipe_rd,
    input  logic [31:0] i_pipe_data,
    input  logic        i_mc_valid,
    output logic        o_mc_ready,
    input  logic [4:0]  i_mc_rd,
    input  logic [31:0] i_mc_data,
    output logic        o_reg_write,
    output logic [4:0]  o_wr_addr,
    output logic [31:0] o_wr_data,
    input  logic [4:0]  i_rd_addr_1,
    input  logic [4:0]  i_rd_addr_2,
    input  logic [31:0] i_rf_data_1,
    input  logic [31:0] i_rf_data_2,
    output logic [31:0] o_rd_data_1,
    output logic [31:0] o_rd_data_2,
    output logic [31:0] o_pending_mask
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    logic [PW-1:0] head_r, tail_r;
    logic [CW-1:0] count_r;
    logic [4:0]    ent_rd_r   [DEPTH];
    logic [31:0]   ent_data_r [DEPTH];
    logic          ent_vld_r  [DEPTH];
    logic          reg_write_r;
    logic [4:0]    wr_addr_r;
    logic [31:0]   wr_data_r;
    logic [31:0]   pending_mask_r;

    logic          pipe_eff_s, mc_ready_s, mc_acc_s, fifo_empty_s;
    logic          pop_s, head_wr_s, mc_drop_s, direct_s, push_s;
    logic          vld_next_s [DEPTH];
    logic [4:0]    rd_next_s  [DEPTH];
    logic [31:0]   mask_next_s;
    logic          reg_write_next_s;
    logic [4:0]    wr_addr_next_s;
    logic [31:0]   wr_data_next_s;

    // Arbitration decisions for this cycle
    always_comb begin
        pipe_eff_s   = i_pipe_we && (i_pipe_rd != 5'd0);
        mc_ready_s   = (count_r < DEPTH_C);
        mc_acc_s     = i_mc_valid && mc_ready_s && i_clk_enable;
        fifo_empty_s = (count_r == {CW{1'b0}});
        pop_s        = i_clk_enable && !pipe_eff_s && !fifo_empty_s;
        head_wr_s    = pop_s && ent_vld_r[head_r];
        // A same-cycle pipeline write to the same rd makes the mc result stale
        mc_drop_s    = (i_mc_rd == 5'd0) || (pipe_eff_s && (i_mc_rd == i_pipe_rd));
        direct_s     = mc_acc_s && !mc_drop_s && !pipe_eff_s && fifo_empty_s;
        push_s       = mc_acc_s && !mc_drop_s && !direct_s;
    end

    // Next FIFO entry state (squash, pop, push) and the pending mask derived from it
    always_comb begin
        mask_next_s = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            vld_next_s[i] = ent_vld_r[i];
            rd_next_s[i]  = ent_rd_r[i];
            if (i_clk_enable && pipe_eff_s && (ent_rd_r[i] == i_pipe_rd)) begin
                vld_next_s[i] = 1'b0;
            end else begin
                vld_next_s[i] = vld_next_s[i];
            end
            if (pop_s && (head_r == PW'(i))) begin
                vld_next_s[i] = 1'b0;
            end else begin
                vld_next_s[i] = vld_next_s[i];
            end
            if (push_s && (tail_r == PW'(i))) begin
                vld_next_s[i] = 1'b1;
                rd_next_s[i]  = i_mc_rd;
            end else begin
                rd_next_s[i]  = rd_next_s[i];
            end
            if (vld_next_s[i]) begin
                mask_next_s[rd_next_s[i]] = 1'b1;
            end else begin
                mask_next_s = mask_next_s;
            end
        end
    end

    // Output stage source selection in priority order
    always_comb begin
        reg_write_next_s = 1'b0;
        wr_addr_next_s   = wr_addr_r;
        wr_data_next_s   = wr_data_r;
        if (pipe_eff_s) begin
            reg_write_next_s = 1'b1;
            wr_addr_next_s   = i_pipe_rd;
            wr_data_next_s   = i_pipe_data;
        end else if (head_wr_s) begin
            reg_write_next_s = 1'b1;
            wr_addr_next_s   = ent_rd_r[head_r];
            wr_data_next_s   = ent_data_r[head_r];
        end else if (direct_s) begin
            reg_write_next_s = 1'b1;
            wr_addr_next_s   = i_mc_rd;
            wr_data_next_s   = i_mc_data;
        end else begin
            reg_write_next_s = 1'b0;
        end
    end

    // State registers; everything holds while the clock enable is low
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head_r         <= {PW{1'b0}};
            tail_r         <= {PW{1'b0}};
            count_r        <= {CW{1'b0}};
            reg_write_r    <= 1'b0;
            wr_addr_r      <= 5'd0;
            wr_data_r      <= 32'd0;
            pending_mask_r <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_vld_r[i]  <= 1'b0;
                ent_rd_r[i]   <= 5'd0;
                ent_data_r[i] <= 32'd0;
            end
        end else if (i_clk_enable) begin
            reg_write_r    <= reg_write_next_s;
            wr_addr_r      <= wr_addr_next_s;
            wr_data_r      <= wr_data_next_s;
            pending_mask_r <= mask_next_s;
            if (pop_s) head_r <= ptr_inc(head_r);
            if (push_s) begin
                tail_r             <= ptr_inc(tail_r);
                ent_data_r[tail_r] <= i_mc_data;
            end
            if (push_s && !pop_s)      count_r <= count_r + CW'(1);
            else if (pop_s && !push_s) count_r <= count_r - CW'(1);
            for (int i = 0; i < DEPTH; i++) begin
                ent_vld_r[i] <= vld_next_s[i];
                ent_rd_r[i]  <= rd_next_s[i];
            end
        end
    end

    assign o_mc_ready     = mc_ready_s;
    assign o_reg_write    = reg_write_r;
    assign o_wr_addr      = wr_addr_r;
    assign o_wr_data      = wr_data_r;
    assign o_pending_mask = pending_mask_r;

`ifdef WB_BYPASS_EN
    // Forward the in-flight write to decode reads of the same register
    always_comb begin
        if (reg_write_r && (wr_addr_r == i_rd_addr_1) && (i_rd_addr_1 != 5'd0)) begin
            o_rd_data_1 = wr_data_r;
        end else begin
            o_rd_data_1 = i_rf_data_1;
        end
        if (reg_write_r && (wr_addr_r == i_rd_addr_2) && (i_rd_addr_2 != 5'd0)) begin
            o_rd_data_2 = wr_data_r;
        end else begin
            o_rd_data_2 = i_rf_data_2;
        end
    end
`else
    assign o_rd_data_1 = i_rf_data_1;
    assign o_rd_data_2 = i_rf_data_2;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter (DEPTH=2).
module tb_wb_write_arbiter;
    logic        clk, rst, en;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        mc_valid, mc_ready;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        reg_write;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_1, rd_addr_2;
    logic [31:0] rf_data_1, rf_data_2, rd_data_1, rd_data_2;
    logic [31:0] pending_mask;
    int          checks_cnt;
    int          errors_cnt;

    wb_write_arbiter #(.DEPTH(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_clk_enable(en),
        .i_pipe_we(pipe_we), .i_pipe_rd(pipe_rd), .i_pipe_data(pipe_data),
        .i_mc_valid(mc_valid), .o_mc_ready(mc_ready), .i_mc_rd(mc_rd), .i_mc_data(mc_data),
        .o_reg_write(reg_write), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .i_rd_addr_1(rd_addr_1), .i_rd_addr_2(rd_addr_2),
        .i_rf_data_1(rf_data_1), .i_rf_data_2(rf_data_2),
        .o_rd_data_1(rd_data_1), .o_rd_data_2(rd_data_2),
        .o_pending_mask(pending_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic we, input logic [4:0] rd, input logic [31:0] d);
        pipe_we = we; pipe_rd = rd; pipe_data = d;
    endtask

    task automatic mc(input logic v, input logic [4:0] rd, input logic [31:0] d);
        mc_valid = v; mc_rd = rd; mc_data = d;
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        check({tag, ".we"}, {31'd0, reg_write}, {31'd0, we});
        if (we) begin
            check({tag, ".addr"}, {27'd0, wr_addr}, {27'd0, a});
            check({tag, ".data"}, wr_data, d);
        end
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst = 1'b1; en = 1'b1;
        pipe(1'b0, 5'd0, 32'd0);
        mc(1'b0, 5'd0, 32'd0);
        rd_addr_1 = 5'd0; rd_addr_2 = 5'd0; rf_data_1 = 32'd0; rf_data_2 = 32'd0;
        step(); step();
        rst = 1'b0;
        check("rst.we",   {31'd0, reg_write}, 32'd0);
        check("rst.addr", {27'd0, wr_addr}, 32'd0);
        check("rst.data", wr_data, 32'd0);
        check("rst.mask", pending_mask, 32'd0);
        check("rst.ready", {31'd0, mc_ready}, 32'd1);

        // Pipe and mc in the same cycle: pipe first, mc next
        pipe(1'b1, 5'd5, 32'h11); mc(1'b1, 5'd6, 32'h22);
        step();
        chk_wr("t1.c1", 1'b1, 5'd5, 32'h11);
        check("t1.mask1", pending_mask, 32'h40);
        pipe(1'b0, 5'd0, 32'd0); mc(1'b0, 5'd0, 32'd0);
        step();
        chk_wr("t1.c2", 1'b1, 5'd6, 32'h22);
        check("t1.mask2", pending_mask, 32'd0);
        step();
        chk_wr("t1.idle", 1'b0, 5'd0, 32'd0);

        // Pipe busy four cycles while mc offers three results
        pipe(1'b1, 5'd1, 32'h01); mc(1'b1, 5'd8, 32'h81);
        step();
        chk_wr("t2.c1", 1'b1, 5'd1, 32'h01);
        check("t2.mask1", pending_mask, 32'h100);
        pipe(1'b1, 5'd2, 32'h02); mc(1'b1, 5'd9, 32'h92);
        step();
        check("t2.ready2", {31'd0, mc_ready}, 32'd0);
        check("t2.mask2", pending_mask, 32'h300);
        pipe(1'b1, 5'd3, 32'h03); mc(1'b1, 5'd10, 32'hA3);
        step();
        check("t2.ready3", {31'd0, mc_ready}, 32'd0);
        pipe(1'b1, 5'd4, 32'h04);
        step();
        chk_wr("t2.c4", 1'b1, 5'd4, 32'h04);
        check("t2.mask4", pending_mask, 32'h300);
        pipe(1'b0, 5'd0, 32'd0); mc(1'b0, 5'd0, 32'd0);
        step();
        chk_wr("t2.q1", 1'b1, 5'd8, 32'h81);
        check("t2.ready5", {31'd0, mc_ready}, 32'd1);
        step();
        chk_wr("t2.q2", 1'b1, 5'd9, 32'h92);
        check("t2.mask6", pending_mask, 32'd0);
        step();
        chk_wr("t2.idle", 1'b0, 5'd0, 32'd0);

        // Squash of a queued entry by a younger pipe write
        pipe(1'b1, 5'd12, 32'hC0); mc(1'b1, 5'd7, 32'hAA);
        step();
        check("t3.mask1", pending_mask, 32'h80);
        pipe(1'b1, 5'd7, 32'hBB); mc(1'b0, 5'd0, 32'd0);
        step();
        chk_wr("t3.pipe", 1'b1, 5'd7, 32'hBB);
        check("t3.mask2", pending_mask, 32'd0);
        pipe(1'b0, 5'd0, 32'd0);
        step();
        chk_wr("t3.squashpop", 1'b0, 5'd0, 32'd0);

        // mc result to x0 is dropped
        mc(1'b1, 5'd0, 32'h55);
        step();
        mc(1'b0, 5'd0, 32'd0);
        chk_wr("t4.x0", 1'b0, 5'd0, 32'd0);
        check("t4.mask", pending_mask, 32'd0);
        check("t4.ready", {31'd0, mc_ready}, 32'd1);

        // Read bypass
        pipe(1'b1, 5'd3, 32'h33);
        step();
        pipe(1'b0, 5'd0, 32'd0);
        rd_addr_1 = 5'd3; rf_data_1 = 32'd0; rd_addr_2 = 5'd4; rf_data_2 = 32'h44;
        #1;
`ifdef WB_BYPASS_EN
        check("t5.byp1", rd_data_1, 32'h33);
`else
        check("t5.byp1", rd_data_1, 32'd0);
`endif
        check("t5.byp2", rd_data_2, 32'h44);

        // Clock enable low: everything holds
        en = 1'b0; pipe(1'b1, 5'd13, 32'hD0);
        step();
        chk_wr("t5.hold", 1'b1, 5'd3, 32'h33);
        en = 1'b1; pipe(1'b0, 5'd0, 32'd0);
        rd_addr_1 = 5'd0; rd_addr_2 = 5'd0; rf_data_2 = 32'd0;

        // Fill the FIFO, then reset
        pipe(1'b1, 5'd14, 32'hE1); mc(1'b1, 5'd15, 32'hF1);
        step();
        pipe(1'b1, 5'd16, 32'hE2); mc(1'b1, 5'd17, 32'hF2);
        step();
        check("t6.full", {31'd0, mc_ready}, 32'd0);
        check("t6.mask", pending_mask, 32'h28000);
        pipe(1'b0, 5'd0, 32'd0); mc(1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6.rst.we", {31'd0, reg_write}, 32'd0);
        check("t6.rst.addr", {27'd0, wr_addr}, 32'd0);
        check("t6.rst.data", wr_data, 32'd0);
        check("t6.rst.mask", pending_mask, 32'd0);
        check("t6.rst.ready", {31'd0, mc_ready}, 32'd1);
        step();
        chk_wr("t6.stale1", 1'b0, 5'd0, 32'd0);
        step();
        chk_wr("t6.stale2", 1'b0, 5'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
